music_sequencer: RTL

Song sequencer that sits directly upstream of `music_timer`. It steps through a fixed song table and drives the timer's `length` code and a pitch code for the tone generator. It advances one table entry per `note_change` pulse returned by the timer, and handles start, stop, end-of-song and optional looping.

---
 rtl/music_sequencer.sv | 113 +++++++++++
 1 files changed

// File: rtl/music_sequencer.sv
// Song sequencer feeding music_timer: walks a fixed 16-entry song table one
// entry per note_change pulse, with start/stop, end-of-song and optional looping.
//
// state | meaning
// IDLE  | stopped, outputs silent, idx held at 0
// FETCH | one-cycle gap (length=0); load entry idx or handle end marker
// PLAY  | entry held on length/pitch until note_change
module music_sequencer #(
  parameter bit LOOP = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       play,
  input  logic       stop,
  input  logic       note_change,
  output logic [3:0] length,
  output logic [5:0] pitch,
  output logic       playing,
  output logic       song_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    PLAY  = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  idx;
  logic [9:0]  entry;
  logic        is_end;

  // {pitch[5:0], len[3:0]}; len outside 1..7 marks the end of the song
  always_comb begin
    entry = 10'd0;
    case (idx)
      4'd0:    entry = {6'd20, 4'd3};
      4'd1:    entry = {6'd22, 4'd3};
      4'd2:    entry = {6'd24, 4'd3};
      4'd3:    entry = {6'd20, 4'd3};
      4'd4:    entry = {6'd27, 4'd2};
      4'd5:    entry = {6'd0,  4'd4};
      4'd6:    entry = {6'd25, 4'd7};
      default: entry = 10'd0;
    endcase
  end

  assign is_end = (entry[3:0] == 4'd0) || (entry[3:0] > 4'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= 4'd0;
      length    <= 4'd0;
      pitch     <= 6'd0;
      playing   <= 1'b0;
      song_done <= 1'b0;
    end else begin
      song_done <= 1'b0;
      if (stop) begin
        state   <= IDLE;
        idx     <= 4'd0;
        length  <= 4'd0;
        pitch   <= 6'd0;
        playing <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            length <= 4'd0;
            pitch  <= 6'd0;
            idx    <= 4'd0;
            if (play) begin
              state   <= FETCH;
              playing <= 1'b1;
            end
          end
          FETCH: begin
            if (!is_end) begin
              length <= entry[3:0];
              pitch  <= entry[9:4];
              state  <= PLAY;
            end else begin
              length    <= 4'd0;
              song_done <= 1'b1;
              idx       <= 4'd0;
              if (!LOOP) begin
                state   <= IDLE;
                playing <= 1'b0;
                pitch   <= 6'd0;
              end
            end
          end
          PLAY: begin
            // pitch is held through the gap; only length drops to restart the timer
            if (note_change) begin
              idx    <= idx + 4'd1;
              length <= 4'd0;
              state  <= FETCH;
            end
          end
          default: begin
            state   <= IDLE;
            idx     <= 4'd0;
            length  <= 4'd0;
            pitch   <= 6'd0;
            playing <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
